// File: rtl/dual_slope_pkg.sv
// dual_slope_pkg
// Shared types and constants for the dual-slope ADC sequencer:
//   - state_t : sequencer states (IDLE, AZ, INT, DEINT)
//   - CH_VM / CH_REF / CH_ZR : bit positions of the switch enables in ch
//   - CH_ENC_* : one-hot switch pattern driven in each state
//   - ch_of() : maps a state to its switch pattern
package dual_slope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AZ    = 2'd1,
        ST_INT   = 2'd2,
        ST_DEINT = 2'd3
    } state_t;

    localparam int CH_VM  = 0;
    localparam int CH_REF = 1;
    localparam int CH_ZR  = 2;

    localparam logic [2:0] CH_ENC_IDLE  = 3'(1 << CH_ZR);
    localparam logic [2:0] CH_ENC_AZ    = 3'(1 << CH_ZR);
    localparam logic [2:0] CH_ENC_INT   = 3'(1 << CH_VM);
    localparam logic [2:0] CH_ENC_DEINT = 3'(1 << CH_REF);

    function automatic logic [2:0] ch_of(input state_t s);
        case (s)
            ST_AZ:    return CH_ENC_AZ;
            ST_INT:   return CH_ENC_INT;
            ST_DEINT: return CH_ENC_DEINT;
            default:  return CH_ENC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dual_slope_cnt.sv
// dual_slope_cnt
// Phase counter shared by all timed phases of the sequencer. Counts up by one
// every cycle unless cleared; tc flags that the count equals the runtime limit.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (count -> 0)
//   clr    - synchronous clear (count -> 0 on next edge)
//   limit  - terminal value compared against the current count
//   cnt    - current count
//   tc     - cnt == limit
module dual_slope_cnt
    import dual_slope_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/dual_slope_ctrl.sv
// dual_slope_ctrl
// Control sequencer for a dual-slope integrating ADC front end. Steps the
// analog switch bank through auto-zero, fixed-time integration and reference
// de-integration, counts the de-integration time and hands the signed-magnitude
// result to the consumer with a valid/ack handshake.
//
// Build option: DUAL_SLOPE_AUTOZERO_EN
//   defined   - an auto-zero phase of N_AZ cycles precedes integration
//   undefined - IDLE goes straight to integration; N_AZ has no effect
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   iniciar             - start request, sampled in IDLE
//   vint_z, vint_pos    - comparator: integrator at zero / integrator positive
//   ack                 - consumer has taken the result
//   ch[2:0]             - one-hot switch enables: [0] input, [1] ref, [2] zero
//   ref_neg             - 1 selects the negative reference during de-integration
//   busy                - conversion in progress
//   valid               - result/negative/overrange hold a fresh result
//   result              - de-integration cycle count
//   negative            - input polarity of the result
//   overrange           - de-integration hit the timeout
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iniciar; zero switch closed
// AZ    | auto-zero for N_AZ cycles (only with DUAL_SLOPE_AUTOZERO_EN)
// INT   | integrate input for N_INT cycles; latch polarity on last cycle
// DEINT | de-integrate reference until zero crossing or T_MAX-1
module dual_slope_ctrl
    import dual_slope_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int N_INT = 2048,
    parameter int T_MAX = 4096,
    parameter int N_AZ  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             vint_z,
    input  logic             vint_pos,
    input  logic             ack,
    output logic [2:0]       ch,
    output logic             ref_neg,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result,
    output logic             negative,
    output logic             overrange
);

    localparam logic [CNT_W-1:0] LIM_AZ    = CNT_W'(N_AZ - 1);
    localparam logic [CNT_W-1:0] LIM_INT   = CNT_W'(N_INT - 1);
    localparam logic [CNT_W-1:0] LIM_DEINT = CNT_W'(T_MAX - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_lim;
    logic             cnt_tc;
    logic             cnt_clr;

    always_comb begin
        cnt_lim = LIM_DEINT;
        case (state)
            ST_AZ:   cnt_lim = LIM_AZ;
            ST_INT:  cnt_lim = LIM_INT;
            default: cnt_lim = LIM_DEINT;
        endcase
    end

    // Clear whenever a phase ends so every phase starts from zero, and clear
    // on a DEINT exit as well so the count never rolls past T_MAX-1.
    assign cnt_clr = (state == ST_IDLE) || cnt_tc ||
                     ((state == ST_DEINT) && vint_z);

    dual_slope_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .limit (cnt_lim),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ch        <= CH_ENC_IDLE;
            ref_neg   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            overrange <= 1'b0;
        end else begin
            // ack drops valid unless a later branch writes a new result.
            if (ack) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (iniciar) begin
                        valid <= 1'b0;
                        busy  <= 1'b1;
`ifdef DUAL_SLOPE_AUTOZERO_EN
                        state <= ST_AZ;
                        ch    <= ch_of(ST_AZ);
`else
                        state <= ST_INT;
                        ch    <= ch_of(ST_INT);
`endif
                    end
                end

`ifdef DUAL_SLOPE_AUTOZERO_EN
                ST_AZ: begin
                    if (cnt_tc) begin
                        state <= ST_INT;
                        ch    <= ch_of(ST_INT);
                    end
                end
`endif

                ST_INT: begin
                    if (cnt_tc) begin
                        ref_neg <= vint_pos;
                        state   <= ST_DEINT;
                        ch      <= ch_of(ST_DEINT);
                    end
                end

                ST_DEINT: begin
                    // Zero crossing takes priority over the timeout.
                    if (vint_z || cnt_tc) begin
                        result    <= cnt;
                        negative  <= ref_neg;
                        overrange <= ~vint_z;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                        ch        <= ch_of(ST_IDLE);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    ch    <= ch_of(ST_IDLE);
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
module tb_dual_slope_ctrl;

    localparam int CNT_W = 5;
    localparam int N_INT = 8;
    localparam int T_MAX = 16;
    localparam int N_AZ  = 4;
`ifdef DUAL_SLOPE_AUTOZERO_EN
    localparam int A_LEN = N_AZ;
`else
    localparam int A_LEN = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             iniciar = 1'b0;
    logic             vint_z = 1'b0;
    logic             vint_pos = 1'b0;
    logic             ack = 1'b0;
    logic [2:0]       ch;
    logic             ref_neg;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] result;
    logic             negative;
    logic             overrange;

    int n_chk = 0;
    int n_bad = 0;

    // model's view of the held outputs
    int m_ref_neg = 0;
    int m_result = 0;
    int m_negative = 0;
    int m_overrange = 0;
    int m_valid = 0;

    always #5 clk = ~clk;

    dual_slope_ctrl #(
        .CNT_W (CNT_W),
        .N_INT (N_INT),
        .T_MAX (T_MAX),
        .N_AZ  (N_AZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iniciar   (iniciar),
        .vint_z    (vint_z),
        .vint_pos  (vint_pos),
        .ack       (ack),
        .ch        (ch),
        .ref_neg   (ref_neg),
        .busy      (busy),
        .valid     (valid),
        .result    (result),
        .negative  (negative),
        .overrange (overrange)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, ".ref_neg"},   32'(ref_neg),   32'(m_ref_neg));
        chk({tag, ".result"},    32'(result),    32'(m_result));
        chk({tag, ".negative"},  32'(negative),  32'(m_negative));
        chk({tag, ".overrange"}, 32'(overrange), 32'(m_overrange));
        chk({tag, ".valid"},     32'(valid),     32'(m_valid));
    endtask

    // One conversion. Entered #1 after an edge with the DUT in IDLE.
    // kz < 0 means the comparator never fires. Cycle j is the one following
    // edge j, with edge 0 the edge that samples iniciar.
    task automatic run_conv(input bit pos, input int kz, input bit hold, input bit noisy);
        int kk;
        int e_end;
        int d;
        logic [2:0] exp_ch;
        kk    = (kz >= 0) ? kz : T_MAX - 1;
        e_end = A_LEN + N_INT + kk + 1;
        iniciar  = 1'b1;
        vint_pos = pos;
        vint_z   = 1'b0;
        ack      = 1'($urandom);
        for (int j = 0; j <= e_end; j++) begin
            if (j > 0) begin
                d = j - 1 - A_LEN - N_INT;
                if (d >= 0)
                    vint_z = (d == kz);
                else
                    vint_z = noisy ? 1'($urandom) : 1'b0;
                vint_pos = (d >= 0) ? 1'($urandom) : pos;
                iniciar  = hold ? 1'b1 : 1'($urandom);
                ack      = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (j == 0)
                m_valid = 0;
            if (j == A_LEN + N_INT)
                m_ref_neg = pos;
            if (j == e_end) begin
                m_result    = kk;
                m_negative  = pos;
                m_overrange = (kz < 0);
                m_valid     = 1;
            end
            if (j < A_LEN)              exp_ch = 3'b100;
            else if (j < A_LEN + N_INT) exp_ch = 3'b001;
            else if (j < e_end)         exp_ch = 3'b010;
            else                        exp_ch = 3'b100;
            chk("ch", 32'(ch), 32'(exp_ch));
            chk("busy", 32'(busy), 32'(j < e_end));
            chk_held("conv");
        end
        iniciar = hold;
        ack     = 1'b0;
        vint_z  = 1'b0;
    endtask

    // Hold valid for a few cycles, then ack and expect it to drop.
    task automatic handshake(input int wait_cyc);
        ack = 1'b0;
        iniciar = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            @(posedge clk);
            #1;
            chk_held("hold");
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        m_valid = 0;
        chk_held("ack");
        chk("ack.busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ref_neg = 0;
        m_result = 0;
        m_negative = 0;
        m_overrange = 0;
        m_valid = 0;
        chk("rst.ch", 32'(ch), 32'b100);
        chk("rst.busy", 32'(busy), 32'd0);
        chk_held("rst");
    endtask

    initial begin
        int kz;
        @(posedge clk);
        #1;
        do_reset();

        // basic conversion, positive integrator, zero at k=5
        run_conv(1'b1, 5, 1'b0, 1'b0);
        handshake(3);

        // opposite polarity, k=3
        run_conv(1'b0, 3, 1'b0, 1'b0);
        handshake(5);

        // timeout
        run_conv(1'b1, -1, 1'b0, 1'b0);
        handshake(1);

        // comparator noise during INT ignored; zero on first DEINT cycle
        run_conv(1'b0, 0, 1'b0, 1'b1);
        handshake(0);

        // zero coincident with the timeout cycle: not overrange
        run_conv(1'b1, T_MAX - 1, 1'b0, 1'b1);
        handshake(2);

        // reset in the middle of INT, then a clean restart
        iniciar = 1'b1;
        vint_pos = 1'b1;
        for (int i = 0; i < A_LEN + 3; i++) begin
            @(posedge clk);
            #1;
            iniciar = 1'b0;
        end
        do_reset();
        run_conv(1'b1, 7, 1'b0, 1'b0);
        handshake(1);

        // back-to-back conversions with iniciar held high
        run_conv(1'b0, 2, 1'b1, 1'b0);
        run_conv(1'b1, 9, 1'b1, 1'b1);
        run_conv(1'b0, -1, 1'b1, 1'b0);
        run_conv(1'b1, 4, 1'b0, 1'b0);
        handshake(2);

        // randomized conversions
        for (int n = 0; n < 25; n++) begin
            kz = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T_MAX - 1));
            run_conv(1'($urandom), kz, 1'($urandom), 1'($urandom));
            if (iniciar == 1'b0 && $urandom_range(0, 1) == 1)
                handshake(int'($urandom_range(0, 3)));
            else if (iniciar == 1'b0) begin
                @(posedge clk);
                #1;
                chk_held("idle");
            end
        end
        iniciar = 1'b0;
        handshake(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
